// File: rtl/alu_accumulator_if.sv
// Operand request channel into alu_accumulator: valid/ready handshake
// carrying one operand plus its operation and clear qualifiers.
interface alu_accumulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_op;
  logic       in_clear;

  modport master (
    output in_valid,
    output in_data,
    output in_op,
    output in_clear,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_op,
    input  in_clear,
    output in_ready
  );
endinterface

// File: rtl/alu_accumulator.sv
// Sequencer around an external 4-bit add/subtract ALU: one operand per
// handshake, accumulator feedback into operand A, carry/borrow and a saturating op count.
module alu_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_accumulator_if.slave req,
  output logic [3:0]       alu_A,
  output logic [3:0]       alu_B,
  output logic             alu_Sel,
  input  logic [3:0]       alu_Res,
  output logic [3:0]       acc,
  output logic             carry,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [3:0]       acc_reg;
  logic [3:0]       opnd_reg;
  logic             op_reg;
  logic             clr_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             accept;
  logic             carry_next;
  logic [4:0]       sum_wide;
  logic             in_ready_int;

  // Handshake flags depend only on state, so in_valid never reaches in_ready.
  always_comb begin
    state_next   = state_reg;
    in_ready_int = 1'b0;
    out_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_int = 1'b1;
        if (req.in_valid) state_next = EXEC;
      end
      EXEC: state_next = DONE;
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req.in_ready = in_ready_int;
  assign accept       = req.in_valid && in_ready_int;

  // Carry/borrow is derived from the operand registers, not from alu_Res.
  assign sum_wide   = {1'b0, acc_reg} + {1'b0, opnd_reg};
  assign carry_next = op_reg ? sum_wide[4] : (acc_reg < opnd_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= 4'd0;
      opnd_reg  <= 4'd0;
      op_reg    <= 1'b0;
      clr_reg   <= 1'b0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        opnd_reg <= req.in_data;
        op_reg   <= req.in_op;
        clr_reg  <= req.in_clear;
      end
      if (state_reg == EXEC) begin
        if (clr_reg) begin
          acc_reg   <= opnd_reg;
          carry_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          acc_reg   <= alu_Res;
          carry_reg <= carry_next;
          if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign alu_A    = acc_reg;
  assign alu_B    = opnd_reg;
  assign alu_Sel  = op_reg;
  assign acc      = acc_reg;
  assign carry    = carry_reg;
  assign op_count = cnt_reg;

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator with a behavioural ALU closing the loop;
// each task checks its own scenario against hand-computed values.
module tb_alu_accumulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] alu_A;
  logic [3:0] alu_B;
  logic       alu_Sel;
  logic [3:0] alu_Res;
  logic [3:0] acc;
  logic       carry;
  logic       out_valid;
  logic [7:0] op_count;
  logic       corrupt = 1'b0;
  logic [3:0] alu_sum;
  logic [3:0] alu_dif;

  int n_checks = 0;
  int n_fail   = 0;

  logic       exec_ready;
  logic       exec_ov;
  logic [3:0] exec_a;
  logic [3:0] exec_b;
  logic       exec_sel;

  alu_accumulator_if req_if ();

  alu_accumulator #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_if),
    .alu_A     (alu_A),
    .alu_B     (alu_B),
    .alu_Sel   (alu_Sel),
    .alu_Res   (alu_Res),
    .acc       (acc),
    .carry     (carry),
    .out_valid (out_valid),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // External ALU; corrupt flips every result bit to prove clears ignore it.
  assign alu_sum = alu_A + alu_B;
  assign alu_dif = alu_A - alu_B;
  assign alu_Res = (alu_Sel ? alu_sum : alu_dif) ^ {4{corrupt}};

  // Drives one request and returns at the falling edge inside DONE.
  task automatic drive_op(input logic [3:0] d, input logic op, input logic clr);
    int n;
    @(negedge clk);
    req_if.in_valid = 1'b1;
    req_if.in_data  = d;
    req_if.in_op    = op;
    req_if.in_clear = clr;
    n = 0;
    while (!req_if.in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!req_if.in_ready) begin
      n_fail++;
      $display("FAIL handshake_timeout: in_ready=%0b after %0d cycles, required 1", req_if.in_ready, n);
    end
    @(posedge clk);
    #1 req_if.in_valid = 1'b0;
    @(negedge clk);
    exec_ready = req_if.in_ready;
    exec_ov    = out_valid;
    exec_a     = alu_A;
    exec_b     = alu_B;
    exec_sel   = alu_Sel;
    @(negedge clk);
    $display("op data=%0d add=%0b clr=%0b -> acc=%0d carry=%0b op_count=%0d out_valid=%0b",
             d, op, clr, acc, carry, op_count, out_valid);
  endtask

  task automatic test_reset();
    req_if.in_valid = 1'b1;
    req_if.in_data  = 4'd6;
    req_if.in_op    = 1'b1;
    req_if.in_clear = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (acc !== 4'd0 || carry !== 1'b0 || op_count !== 8'd0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: acc=%0d carry=%0b cnt=%0d ov=%0b, required 0/0/0/0", acc, carry, op_count, out_valid);
      end
      n_checks++;
      if (req_if.in_ready !== 1'b1 || alu_B !== 4'd0 || alu_Sel !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_regs: in_ready=%0b alu_B=%0d alu_Sel=%0b, required 1/0/0", req_if.in_ready, alu_B, alu_Sel);
      end
    end
    req_if.in_valid = 1'b0;
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_add_sub();
    drive_op(4'd5, 1'b1, 1'b0);
    n_checks++;
    if (exec_ready !== 1'b0 || exec_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_flags: in_ready=%0b out_valid=%0b, required 0/0", exec_ready, exec_ov);
    end
    n_checks++;
    if (acc !== 4'd5 || carry !== 1'b0 || op_count !== 8'd1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL add5: acc=%0d carry=%0b cnt=%0d ov=%0b, required 5/0/1/1", acc, carry, op_count, out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || req_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_width: out_valid=%0b in_ready=%0b, required 0/1", out_valid, req_if.in_ready);
    end

    drive_op(4'd12, 1'b1, 1'b0);
    n_checks++;
    if (exec_a !== 4'd5 || exec_b !== 4'd12 || exec_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_operands: A=%0d B=%0d Sel=%0b, required 5/12/1", exec_a, exec_b, exec_sel);
    end
    n_checks++;
    if (acc !== 4'd1 || carry !== 1'b1 || op_count !== 8'd2) begin
      n_fail++;
      $display("FAIL add12: acc=%0d carry=%0b cnt=%0d, required 1/1/2", acc, carry, op_count);
    end

    drive_op(4'd3, 1'b0, 1'b0);
    n_checks++;
    if (acc !== 4'd14 || carry !== 1'b1 || op_count !== 8'd3 || exec_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL sub3: acc=%0d carry=%0b cnt=%0d sel=%0b, required 14/1/3/0", acc, carry, op_count, exec_sel);
    end

    drive_op(4'd6, 1'b0, 1'b0);
    n_checks++;
    if (acc !== 4'd8 || carry !== 1'b0 || op_count !== 8'd4) begin
      n_fail++;
      $display("FAIL sub6: acc=%0d carry=%0b cnt=%0d, required 8/0/4", acc, carry, op_count);
    end
  endtask

  task automatic test_clear();
    corrupt = 1'b1;
    drive_op(4'd9, 1'b0, 1'b1);
    corrupt = 1'b0;
    n_checks++;
    if (acc !== 4'd9 || carry !== 1'b0 || op_count !== 8'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clear9: acc=%0d carry=%0b cnt=%0d ov=%0b, required 9/0/0/1", acc, carry, op_count, out_valid);
    end
    drive_op(4'd0, 1'b0, 1'b1);
    drive_op(4'd1, 1'b0, 1'b0);
    n_checks++;
    if (acc !== 4'd15 || carry !== 1'b1 || op_count !== 8'd1) begin
      n_fail++;
      $display("FAIL sub_wrap: acc=%0d carry=%0b cnt=%0d, required 15/1/1", acc, carry, op_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_acc;
    logic       exp_carry;
    drive_op(4'd0, 1'b0, 1'b1);
    @(negedge clk);
    req_if.in_valid = 1'b1;
    req_if.in_data  = 4'd1;
    req_if.in_op    = 1'b1;
    req_if.in_clear = 1'b0;
    for (int k = 0; k < 48; k++) begin
      n_checks++;
      if (req_if.in_ready !== (k % 3 == 0) || out_valid !== (k % 3 == 2)) begin
        n_fail++;
        $display("FAIL b2b_phase k=%0d: in_ready=%0b out_valid=%0b, required %0b/%0b",
                 k, req_if.in_ready, out_valid, (k % 3 == 0), (k % 3 == 2));
      end
      if (k % 3 == 2) begin
        exp_acc   = 4'((k / 3) + 1);
        exp_carry = (k / 3 == 15);
        n_checks++;
        if (acc !== exp_acc || carry !== exp_carry) begin
          n_fail++;
          $display("FAIL b2b_acc step=%0d: acc=%0d carry=%0b, required %0d/%0b", k / 3, acc, carry, exp_acc, exp_carry);
        end
        $display("b2b step=%0d acc=%0d carry=%0b", k / 3, acc, carry);
      end
      if (k == 47) req_if.in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    drive_op(4'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      drive_op(4'd0, 1'b1, 1'b0);
      if (i == 254) begin
        n_checks++;
        if (op_count !== 8'd254) begin
          n_fail++;
          $display("FAIL count_254: op_count=%0d, required 254", op_count);
        end
      end
    end
    n_checks++;
    if (op_count !== 8'd255 || acc !== 4'd0 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL saturate: op_count=%0d acc=%0d carry=%0b, required 255/0/0", op_count, acc, carry);
    end
    drive_op(4'd4, 1'b1, 1'b1);
    n_checks++;
    if (op_count !== 8'd0 || acc !== 4'd4) begin
      n_fail++;
      $display("FAIL sat_clear: op_count=%0d acc=%0d, required 0/4", op_count, acc);
    end
  endtask

  task automatic test_reset_mid_exec();
    drive_op(4'd3, 1'b1, 1'b1);
    drive_op(4'd4, 1'b1, 1'b0);
    n_checks++;
    if (acc !== 4'd7 || op_count !== 8'd1) begin
      n_fail++;
      $display("FAIL pre_reset: acc=%0d cnt=%0d, required 7/1", acc, op_count);
    end
    @(negedge clk);
    req_if.in_valid = 1'b1;
    req_if.in_data  = 4'd5;
    req_if.in_op    = 1'b1;
    req_if.in_clear = 1'b0;
    @(posedge clk);
    #1 req_if.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (acc !== 4'd0 || carry !== 1'b0 || op_count !== 8'd0 || out_valid !== 1'b0 || req_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_exec_reset: acc=%0d carry=%0b cnt=%0d ov=%0b rdy=%0b, required 0/0/0/0/1",
               acc, carry, op_count, out_valid, req_if.in_ready);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || acc !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_hold: out_valid=%0b acc=%0d, required 0/0", out_valid, acc);
      end
    end
    rst_n = 1'b1;
    drive_op(4'd2, 1'b1, 1'b0);
    n_checks++;
    if (acc !== 4'd2 || carry !== 1'b0 || op_count !== 8'd1) begin
      n_fail++;
      $display("FAIL post_reset_add: acc=%0d carry=%0b cnt=%0d, required 2/0/1", acc, carry, op_count);
    end
  endtask

  initial begin
    req_if.in_valid = 1'b0;
    req_if.in_data  = 4'd0;
    req_if.in_op    = 1'b0;
    req_if.in_clear = 1'b0;
    test_reset();
    test_add_sub();
    test_clear();
    test_back_to_back();
    test_saturation();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_accumulator.md
# alu_accumulator

Sequencing and accumulation stage wrapped around the 4-bit add/subtract ALU. It accepts one operand per handshake and drives the ALU operands and select. It captures the ALU result into a 4-bit accumulator that feeds back as the next A operand. It also exports a carry/borrow flag, a one-cycle result strobe and a saturating operation count to the surrounding datapath.

## Interface
Parameters:
- CNT_W, 8, width of the operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  4  operand value.
- in_op  input  1  operation select: 1 = add, 0 = subtract. Same encoding as the ALU Sel.
- in_clear  input  1  load in_data directly into the accumulator. in_op is ignored.
- alu_A  output  4  ALU operand A, equal to the accumulator.
- alu_B  output  4  ALU operand B, equal to the operand register.
- alu_Sel  output  1  ALU select, equal to the op register.
- alu_Res  input  4  ALU result. Combinational from alu_A/alu_B/alu_Sel.
- acc  output  4  accumulator value.
- carry  output  1  add: carry out. Subtract: borrow.
- out_valid  output  1  one-cycle strobe: acc and carry updated.
- op_count  output  CNT_W  number of add/sub operations since the last clear or reset. Saturating.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: opnd_reg <= in_data, op_reg <= in_op, clr_reg <= in_clear. Go to EXEC.
- EXEC:
  - in_ready = 0. ALU inputs are stable for the whole cycle.
  - At the clock edge ending EXEC, if clr_reg = 1:
    - acc <= opnd_reg.
    - carry <= 0.
    - op_count <= 0.
  - At the clock edge ending EXEC, if clr_reg = 0:
    - acc <= alu_Res.
    - carry: for add, bit 4 of the 5-bit sum {0,A}+{0,B}. For subtract, (A < B) unsigned.
    - op_count <= op_count + 1, saturating at 2^CNT_W − 1.
  - Go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - Go to IDLE unconditionally.
- alu_A, alu_B and alu_Sel are driven continuously from registers, never from inputs directly.
- Arithmetic is 4-bit unsigned modulo 16. The block does not check alu_Res. carry is computed locally from alu_A and alu_B.
- in_valid asserted outside IDLE is ignored and not queued. The requester must hold in_valid until in_ready.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - acc = 0, opnd_reg = 0, op_reg = 0, clr_reg = 0.
  - carry = 0, out_valid = 0, op_count = 0.
  - in_ready reads 1, but no transfer is accepted while rst_n is low.
- Reset asserted in EXEC or DONE: the in-flight operation is discarded and no out_valid is produced. The first transfer can be accepted on the first rising edge after rst_n deasserts.
- Latency: accepted at edge N. acc and carry update at edge N+1. out_valid is high during cycle N+1→N+2. in_ready returns at N+2.
- Throughput: one operation per 3 cycles with back-to-back in_valid.
- in_ready and out_valid are decoded from state, with no combinational path from in_valid.
- Overflow and wrap:
  - Add 15+1 gives acc = 0, carry = 1.
  - Subtract 0−1 gives acc = 15, carry = 1.
- Saturation: once op_count reaches 2^CNT_W − 1 it holds. A clear returns it to 0.

## Test plan
- Reset, then add 5: in_ready = 1 at first edge. acc = 5, carry = 0, op_count = 1. out_valid is high exactly one cycle, two cycles after acceptance.
- From acc = 5, add 12: acc = 1, carry = 1, op_count = 2. Then subtract 3: acc = 14, carry = 1 (borrow), op_count = 3.
- Clear with in_data = 9, in_op = 0: acc = 9, carry = 0, op_count = 0. alu_Res is ignored in that cycle.
- in_valid held high continuously with adds of 1 from acc = 0:
  - One acceptance every 3 cycles.
  - acc sequence 1, 2, …, 15, 0. carry = 1 only on the 15→0 step.
  - in_ready is never high in EXEC or DONE.
- 300 adds of 0 with CNT_W = 8: op_count stops at 255. acc stays 0.
- Accumulate to acc = 7, accept a new add, assert rst_n low mid-EXEC:
  - Outputs are zero immediately, with no out_valid.
  - After release, add 2 gives acc = 2.
